// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle ARM controller.
//   state_t     : main FSM state encoding (FETCH = 0, used as the debug State value)
//   SRCA_* / SRCB_* / RES_* : datapath multiplexer select codes
//   OP_*        : Instr[27:26] instruction class codes
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        DECODE     = 4'd1,
        MEMADR     = 4'd2,
        MEMREAD    = 4'd3,
        MEMWB      = 4'd4,
        MEMWRITE   = 4'd5,
        EXECUTER   = 4'd6,
        EXECUTEI   = 4'd7,
        ALUWB      = 4'd8,
        BRANCH     = 4'd9,
        EXECUTEMUL = 4'd10,
        MULWB      = 4'd11,
        FPEXEC     = 4'd12,
        FPWB       = 4'd13
    } state_t;

    localparam logic [1:0] SRCA_A        = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;

    localparam logic [1:0] SRCB_WD       = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_4        = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP         = 2'b00;
    localparam logic [1:0] OP_MEM        = 2'b01;
    localparam logic [1:0] OP_BR         = 2'b10;
    localparam logic [1:0] OP_FP         = 2'b11;

endpackage

// File: rtl/mainfsm_outdec.sv
// Moore output decoder: maps the current state to the datapath control word.
// Ports:
//   i_state       current FSM state
//   o_adr_src     memory address select (0 = PC, 1 = Result)
//   o_alu_src_a   ALU A select
//   o_alu_src_b   ALU B select
//   o_result_src  result bus select
//   o_reg_w       register write request
//   o_mem_w       memory write request
//   o_branch      branch request
//   o_alu_op      ALU decoder uses Funct
//   o_reg_src_64b multiply register-field mapping (Moore part only)
//   o_fpu_write   FP register file write
module mainfsm_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     i_state,
    output logic       o_adr_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_result_src,
    output logic       o_reg_w,
    output logic       o_mem_w,
    output logic       o_branch,
    output logic       o_alu_op,
    output logic       o_reg_src_64b,
    output logic       o_fpu_write
);

    always_comb begin
        o_adr_src     = 1'b0;
        o_alu_src_a   = SRCA_A;
        o_alu_src_b   = SRCB_WD;
        o_result_src  = RES_ALUOUT;
        o_reg_w       = 1'b0;
        o_mem_w       = 1'b0;
        o_branch      = 1'b0;
        o_alu_op      = 1'b0;
        o_reg_src_64b = 1'b0;
        o_fpu_write   = 1'b0;
        case (i_state)
            FETCH, DECODE: begin
                o_alu_src_a  = SRCA_PC;
                o_alu_src_b  = SRCB_4;
                o_result_src = RES_ALURESULT;
            end
            MEMADR:   o_alu_src_b = SRCB_IMM;
            MEMREAD:  o_adr_src   = 1'b1;
            MEMWB: begin
                o_result_src = RES_DATA;
                o_reg_w      = 1'b1;
            end
            MEMWRITE: begin
                o_adr_src = 1'b1;
                o_mem_w   = 1'b1;
            end
            EXECUTER: o_alu_op = 1'b1;
            EXECUTEI: begin
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = 1'b1;
            end
            ALUWB:    o_reg_w = 1'b1;
            BRANCH: begin
                o_alu_src_b  = SRCB_IMM;
                o_result_src = RES_ALURESULT;
                o_branch     = 1'b1;
            end
            EXECUTEMUL: begin
                o_reg_src_64b = 1'b1;
                o_alu_op      = 1'b1;
            end
            MULWB: begin
                o_reg_src_64b = 1'b1;
                o_reg_w       = 1'b1;
            end
            FPWB:     o_fpu_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// Main sequencing FSM of the multicycle ARM controller.
// Holds the state register and next-state logic and merges the Mealy terms
// (IRWrite/NextPC in FETCH, RegSrc64b in DECODE, Src_64b in MULWB) onto the
// Moore control word from mainfsm_outdec.
// Ports: clk/reset (async, active-high), Op/Funct/Mul instruction fields,
// MemReady handshake; datapath selects, write requests and debug State out.
module mainfsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       Mul,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       RegSrc64b,
    output logic       Src_64b,
    output logic       FPUWrite,
    output logic [3:0] State
);

    state_t r_state;
    state_t w_next_state;
    logic   w_reg_src_64b_moore;
    logic   w_unused_funct;

    assign w_unused_funct = ^{Funct[4], Funct[2:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:      w_next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_MEM:  w_next_state = MEMADR;
                    OP_BR:   w_next_state = BRANCH;
                    OP_FP:   w_next_state = FPEXEC;
                    default: begin
                        // Immediate form wins over the multiply pattern.
                        if (Funct[5])  w_next_state = EXECUTEI;
                        else if (Mul)  w_next_state = EXECUTEMUL;
                        else           w_next_state = EXECUTER;
                    end
                endcase
            end
            MEMADR:     w_next_state = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:    w_next_state = MemReady ? MEMWB : MEMREAD;
            MEMWB:      w_next_state = FETCH;
            MEMWRITE:   w_next_state = MemReady ? FETCH : MEMWRITE;
            EXECUTER:   w_next_state = ALUWB;
            EXECUTEI:   w_next_state = ALUWB;
            ALUWB:      w_next_state = FETCH;
            BRANCH:     w_next_state = FETCH;
            EXECUTEMUL: w_next_state = MULWB;
            MULWB:      w_next_state = FETCH;
            FPEXEC:     w_next_state = FPWB;
            FPWB:       w_next_state = FETCH;
            default:    w_next_state = FETCH;
        endcase
    end

    mainfsm_outdec u_outdec (
        .i_state       (r_state),
        .o_adr_src     (AdrSrc),
        .o_alu_src_a   (ALUSrcA),
        .o_alu_src_b   (ALUSrcB),
        .o_result_src  (ResultSrc),
        .o_reg_w       (RegW),
        .o_mem_w       (MemW),
        .o_branch      (Branch),
        .o_alu_op      (ALUOp),
        .o_reg_src_64b (w_reg_src_64b_moore),
        .o_fpu_write   (FPUWrite)
    );

    // IR load and PC increment happen together on the cycle the fetch completes.
    assign IRWrite   = (r_state == FETCH) && MemReady;
    assign NextPC    = (r_state == FETCH) && MemReady;
    // Register-field remap must already be in effect in DECODE so the
    // multiply operands are read from the right fields.
    assign RegSrc64b = w_reg_src_64b_moore || ((r_state == DECODE) && Mul);
    assign Src_64b   = (r_state == MULWB) && Funct[3];
    assign State     = r_state;

endmodule

// File: doc/mainfsm.md
# mainfsm

Main sequencing state machine of the multicycle ARM controller. It sits directly upstream of the datapath and steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath's multiplexer selects and write enables and covers the 64-bit multiply path and the FPU path. It emits raw `RegW`, `MemW`, `NextPC`, `Branch` and `ALUOp`; the condition/ALU decoder gates and decodes these into `RegWrite`, `PCWrite` and `ALUControl`.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces state FETCH.
- `Op`  in  2  Instr[27:26].
- `Funct`  in  6  Instr[25:20].
- `Mul`  in  1  1 when Op=00, Funct[5]=0 and Instr[7:4]=1001.
- `MemReady`  in  1  memory completes the current access this cycle.
- `IRWrite`  out  1  instruction register load.
- `AdrSrc`  out  1  0 = PC, 1 = Result.
- `ALUSrcA`  out  2  00 = A, 01 = PC.
- `ALUSrcB`  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4.
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `NextPC`  out  1  unconditional PC write request.
- `RegW`  out  1  register write request.
- `MemW`  out  1  memory write request.
- `Branch`  out  1  branch request.
- `ALUOp`  out  1  1 = ALU decoder uses Funct; 0 = add.
- `RegSrc64b`  out  1  multiply register-field mapping.
- `Src_64b`  out  1  64-bit register writeback.
- `FPUWrite`  out  1  FP register file write.
- `State`  out  4  current state, for debug.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, EXECUTEMUL, MULWB, FPEXEC, FPWB.

All outputs default to 0; select fields not listed for a state are 00. Per state:
- **FETCH:** AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=MemReady. Go to DECODE when MemReady, else stay.
- **DECODE:** ALUSrcA=01, ALUSrcB=10, ResultSrc=10. RegSrc64b=Mul (Mealy), so the multiply operands latch correctly. Next state:
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → FPEXEC.
  - Op=00 with Funct[5]=1 → EXECUTEI.
  - Op=00 with Mul → EXECUTEMUL.
  - otherwise → EXECUTER.
- **MEMADR:** ALUSrcB=01. Funct[0]=1 → MEMREAD, else MEMWRITE.
- **MEMREAD:** AdrSrc=1. Stays while !MemReady, then → MEMWB.
- **MEMWB:** ResultSrc=01, RegW=1 → FETCH.
- **MEMWRITE:** AdrSrc=1, MemW=1. Stays while !MemReady, then → FETCH.
- **EXECUTER:** ALUOp=1 → ALUWB.
- **EXECUTEI:** ALUSrcB=01, ALUOp=1 → ALUWB.
- **ALUWB:** RegW=1 → FETCH.
- **BRANCH:** ALUSrcB=01, ResultSrc=10, Branch=1 → FETCH.
- **EXECUTEMUL:** RegSrc64b=1, ALUOp=1 → MULWB.
- **MULWB:** RegSrc64b=1, RegW=1, Src_64b=Funct[3] (long multiply) → FETCH.
- **FPEXEC:** all outputs 0; the FPU result latches at the end of this cycle → FPWB.
- **FPWB:** FPUWrite=1 → FETCH.

Any unused State encoding → FETCH on the next edge.

## Timing
- Moore outputs are decoded from the state register; the Mealy terms are IRWrite, NextPC, RegSrc64b in DECODE, and Src_64b (from Funct).
- Cycles per instruction with MemReady held at 1:
  - load 5;
  - store 4;
  - ALU register/immediate 4;
  - branch 3;
  - multiply 4;
  - FP 4.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. MemW stays asserted and the address stays stable throughout.
- While reset is high: State=FETCH. Outputs are then the FETCH decode: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, and IRWrite=NextPC=MemReady, which is legal because the datapath is also held in reset.
- Reset asserted mid-instruction: the pending write is abandoned and FETCH is entered asynchronously.
- After reset deasserts, the first transition happens on the next rising edge.
- Op, Funct and Mul are sampled only in DECODE, MEMADR and MULWB. They are stable there because IRWrite=0 outside FETCH.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state enum (4-bit, FETCH=0);
  - the ALUSrcA, ALUSrcB and ResultSrc select constants;
  - the Op codes MEM=01, BR=10, FP=11.
- One sub-module, `mainfsm_outdec`: combinational state → Moore control word. `mainfsm` contains the state register, next-state logic and Mealy terms.

## Test plan
- Reset pulse mid-MEMWRITE → State=0 immediately, MemW=0, IRWrite tracks MemReady.
- LDR (Op=01, Funct=011001), MemReady=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegW=1 only in cycle 5 with ResultSrc=01.
- STR with MemReady low for 3 cycles in MEMWRITE → MemW high for 4 cycles, AdrSrc=1, then FETCH; RegW never asserted.
- UMULL (Op=00, Funct=001000, Mul=1) → RegSrc64b=1 in DECODE, EXECUTEMUL and MULWB; Src_64b=1 and RegW=1 in MULWB only.
- FP add (Op=11) → FPEXEC then FPWB with FPUWrite=1 for exactly one cycle; RegW=MemW=0 throughout.
- B (Op=10) → Branch=1, ALUSrcB=01, ResultSrc=10 in cycle 3; next cycle is FETCH. FETCH with MemReady=0 for 2 cycles → IRWrite=0 and State=FETCH until MemReady=1.
